// File: rtl/issue_scoreboard.sv
// Issue-stage interlock: per-register pending-writer counters for GPR, FPR and
// EFLAGS, checked against each decoded usage record to hold issue on RAW
// hazards or counter saturation.
package issue_scoreboard_pkg;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic [IDX_W-1:0] d;
    logic [IDX_W-1:0] s;
    logic [IDX_W-1:0] t;
    logic             from_gd;
    logic             from_fd;
    logic             to_gd;
    logic             to_fd;
    logic             from_gs;
    logic             from_fs;
    logic             from_gt;
    logic             from_ft;
    logic             from_ef;
    logic             to_ef;
  } rut_t;
endpackage

module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    issue_valid,
  input  rut_t                    rut,
  output logic                    issue_ready,
  output logic                    issue_fire,
  input  logic                    wb_g_valid,
  input  logic [$clog2(NREG)-1:0] wb_g_idx,
  input  logic                    wb_f_valid,
  input  logic [$clog2(NREG)-1:0] wb_f_idx,
  input  logic                    wb_ef_valid,
  input  logic                    flush,
  output logic [NREG-1:0]         gpr_busy,
  output logic [NREG-1:0]         fpr_busy,
  output logic                    ef_busy,
  output logic [31:0]             stall_cnt
);
  localparam int IW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] g_cnt_q [NREG];
  logic [CNT_W-1:0] g_cnt_d [NREG];
  logic [CNT_W-1:0] f_cnt_q [NREG];
  logic [CNT_W-1:0] f_cnt_d [NREG];
  logic [CNT_W-1:0] ef_cnt_q, ef_cnt_d;
  logic [CNT_W-1:0] g_eff [NREG];
  logic [CNT_W-1:0] f_eff [NREG];
  logic [CNT_W-1:0] ef_eff;
  logic [NREG-1:0]  g_dec, f_dec, g_inc, f_inc;
  logic             ef_dec, ef_inc;
  logic             raw, sat;
  logic [31:0]      stall_q, stall_d;

  // Effective counts: a retire this cycle already counts as released.
  // A retire of an idle counter is ignored so the count cannot wrap.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      g_dec[i] = wb_g_valid && (wb_g_idx == IW'(i)) && (g_cnt_q[i] != '0);
      f_dec[i] = wb_f_valid && (wb_f_idx == IW'(i)) && (f_cnt_q[i] != '0);
      g_eff[i] = g_cnt_q[i] - CNT_W'(g_dec[i]);
      f_eff[i] = f_cnt_q[i] - CNT_W'(f_dec[i]);
    end
    ef_dec = wb_ef_valid && (ef_cnt_q != '0);
    ef_eff = ef_cnt_q - CNT_W'(ef_dec);
  end

  // Hazard and saturation check against the effective counts.
  always_comb begin
    raw = (rut.from_gs && (g_eff[rut.s] != '0)) ||
          (rut.from_gt && (g_eff[rut.t] != '0)) ||
          (rut.from_gd && (g_eff[rut.d] != '0)) ||
          (rut.from_fs && (f_eff[rut.s] != '0)) ||
          (rut.from_ft && (f_eff[rut.t] != '0)) ||
          (rut.from_fd && (f_eff[rut.d] != '0)) ||
          (rut.from_ef && (ef_eff != '0));
    sat = (rut.to_gd && (g_eff[rut.d] == CMAX)) ||
          (rut.to_fd && (f_eff[rut.d] == CMAX)) ||
          (rut.to_ef && (ef_eff == CMAX));
    issue_ready = ~flush & ~raw & ~sat;
    issue_fire  = issue_valid & issue_ready;
  end

  // Counter next state; saturation check guarantees inc never overflows.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      g_inc[i]   = issue_fire && rut.to_gd && (rut.d == IDX_W'(i));
      f_inc[i]   = issue_fire && rut.to_fd && (rut.d == IDX_W'(i));
      g_cnt_d[i] = g_cnt_q[i] + CNT_W'(g_inc[i]) - CNT_W'(g_dec[i]);
      f_cnt_d[i] = f_cnt_q[i] + CNT_W'(f_inc[i]) - CNT_W'(f_dec[i]);
      if (flush) begin
        g_cnt_d[i] = '0;
        f_cnt_d[i] = '0;
      end
    end
    ef_inc   = issue_fire && rut.to_ef;
    ef_cnt_d = flush ? '0 : ef_cnt_q + CNT_W'(ef_inc) - CNT_W'(ef_dec);
  end

  // Saturating count of cycles an instruction waited on the scoreboard.
  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        g_cnt_q[i] <= '0;
        f_cnt_q[i] <= '0;
      end
      ef_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      g_cnt_q  <= g_cnt_d;
      f_cnt_q  <= f_cnt_d;
      ef_cnt_q <= ef_cnt_d;
      stall_q  <= stall_d;
    end
  end

  // Busy views decode the registered counters only.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      gpr_busy[i] = (g_cnt_q[i] != '0);
      fpr_busy[i] = (f_cnt_q[i] != '0);
    end
    ef_busy   = (ef_cnt_q != '0);
    stall_cnt = stall_q;
  end

`ifndef SYNTHESIS
  // Flag a retire that has no pending writer behind it.
  always @(posedge clk) begin
    if (rstn && !flush) begin
      if (wb_g_valid && (g_cnt_q[wb_g_idx] == '0))
        $error("issue_scoreboard: GPR %0d retired with no pending writer", wb_g_idx);
      if (wb_f_valid && (f_cnt_q[wb_f_idx] == '0))
        $error("issue_scoreboard: FPR %0d retired with no pending writer", wb_f_idx);
      if (wb_ef_valid && (ef_cnt_q == '0))
        $error("issue_scoreboard: EFLAGS retired with no pending writer");
    end
  end
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: the driver applies one vector per
// cycle and queues its hand-computed response; the monitor compares.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  rut_t        rut;
  logic        issue_ready, issue_fire;
  logic        wb_g_valid, wb_f_valid, wb_ef_valid, flush;
  logic [4:0]  wb_g_idx, wb_f_idx;
  logic [31:0] gpr_busy, fpr_busy, stall_cnt;
  logic        ef_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        rdy;
    logic        fire;
    logic [31:0] gb;
    logic [31:0] fb;
    logic        ef;
    logic [31:0] st;
  } exp_t;

  exp_t expq[$];

  issue_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .rut(rut),
    .issue_ready(issue_ready), .issue_fire(issue_fire),
    .wb_g_valid(wb_g_valid), .wb_g_idx(wb_g_idx),
    .wb_f_valid(wb_f_valid), .wb_f_idx(wb_f_idx),
    .wb_ef_valid(wb_ef_valid), .flush(flush),
    .gpr_busy(gpr_busy), .fpr_busy(fpr_busy), .ef_busy(ef_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic rut_t op_nop();
    rut_t r;
    r = '0;
    return r;
  endfunction

  function automatic rut_t op_add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    rut_t r;
    r = '0; r.d = d; r.s = s; r.t = t;
    r.from_gs = 1'b1; r.from_gt = 1'b1; r.to_gd = 1'b1;
    return r;
  endfunction

  function automatic rut_t op_addi(input logic [4:0] d, input logic [4:0] s);
    rut_t r;
    r = '0; r.d = d; r.s = s;
    r.from_gs = 1'b1; r.to_gd = 1'b1;
    return r;
  endfunction

  function automatic rut_t op_fop(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    rut_t r;
    r = '0; r.d = d; r.s = s; r.t = t;
    r.from_fs = 1'b1; r.from_ft = 1'b1; r.to_fd = 1'b1;
    return r;
  endfunction

  function automatic rut_t op_cmp(input logic [4:0] s, input logic [4:0] t);
    rut_t r;
    r = '0; r.s = s; r.t = t;
    r.from_gs = 1'b1; r.from_gt = 1'b1; r.to_ef = 1'b1;
    return r;
  endfunction

  function automatic rut_t op_je();
    rut_t r;
    r = '0; r.from_ef = 1'b1;
    return r;
  endfunction

  task automatic push(input string nm, input logic rdy, input logic fire,
                      input logic [31:0] gb, input logic [31:0] fb,
                      input logic ef, input logic [31:0] st);
    exp_t e;
    e.nm = nm; e.rdy = rdy; e.fire = fire; e.gb = gb; e.fb = fb; e.ef = ef; e.st = st;
    expq.push_back(e);
  endtask

  // One cycle: inputs change just after the falling edge.
  task automatic cyc(input string nm, input logic v, input rut_t r, input logic fl,
                     input logic gv, input logic [4:0] gi,
                     input logic fv, input logic [4:0] fi, input logic ev,
                     input logic rdy, input logic fire,
                     input logic [31:0] gb, input logic [31:0] fb,
                     input logic ef, input logic [31:0] st);
    @(negedge clk);
    issue_valid = v; rut = r; flush = fl;
    wb_g_valid = gv; wb_g_idx = gi;
    wb_f_valid = fv; wb_f_idx = fi;
    wb_ef_valid = ev;
    push(nm, rdy, fire, gb, fb, ef, st);
  endtask

  // Monitor: compares every queued expectation mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (issue_ready !== e.rdy || issue_fire !== e.fire || gpr_busy !== e.gb ||
            fpr_busy !== e.fb || ef_busy !== e.ef || stall_cnt !== e.st) begin
          errors++;
          $display("FAIL %s: got rdy=%b fire=%b gb=%h fb=%h ef=%b st=%0d want rdy=%b fire=%b gb=%h fb=%h ef=%b st=%0d",
                   e.nm, issue_ready, issue_fire, gpr_busy, fpr_busy, ef_busy, stall_cnt,
                   e.rdy, e.fire, e.gb, e.fb, e.ef, e.st);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    issue_valid = 1'b0; rut = '0; flush = 1'b0;
    wb_g_valid = 1'b0; wb_g_idx = '0;
    wb_f_valid = 1'b0; wb_f_idx = '0; wb_ef_valid = 1'b0;

    cyc("reset",     0, op_nop(),           0, 0,0, 0,0, 0,  1,0, 32'h0,  32'h0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    // ADD d3 then dependent ADDI d4,s3
    cyc("add3",      1, op_add(3,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 0);
    cyc("busy3",     0, op_nop(),           0, 0,0, 0,0, 0,  1,0, 32'h8,  32'h0, 0, 0);
    cyc("addi_raw",  1, op_addi(4,3),       0, 0,0, 0,0, 0,  0,0, 32'h8,  32'h0, 0, 0);
    cyc("addi_wb",   1, op_addi(4,3),       0, 1,3, 0,0, 0,  1,1, 32'h8,  32'h0, 0, 1);
    cyc("busy4",     0, op_nop(),           0, 1,4, 0,0, 0,  1,0, 32'h10, 32'h0, 0, 1);

    // Saturate G5 at three writers
    cyc("add5a",     1, op_add(5,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 1);
    cyc("add5b",     1, op_add(5,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h20, 32'h0, 0, 1);
    cyc("add5c",     1, op_add(5,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h20, 32'h0, 0, 1);
    cyc("add5_sat",  1, op_add(5,1,2),      0, 0,0, 0,0, 0,  0,0, 32'h20, 32'h0, 0, 1);
    cyc("add5_wb",   1, op_add(5,1,2),      0, 1,5, 0,0, 0,  1,1, 32'h20, 32'h0, 0, 2);
    cyc("drain5a",   0, op_nop(),           0, 1,5, 0,0, 0,  1,0, 32'h20, 32'h0, 0, 2);
    cyc("drain5b",   0, op_nop(),           0, 1,5, 0,0, 0,  1,0, 32'h20, 32'h0, 0, 2);
    cyc("drain5c",   0, op_nop(),           0, 1,5, 0,0, 0,  1,0, 32'h20, 32'h0, 0, 2);

    // FPR dependency F2 -> F3
    cyc("fadd2",     1, op_fop(2,0,1),      0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 2);
    cyc("fmul_raw",  1, op_fop(3,2,0),      0, 0,0, 0,0, 0,  0,0, 32'h0,  32'h4, 0, 2);
    cyc("fmul_wb",   1, op_fop(3,2,0),      0, 0,0, 1,2, 0,  1,1, 32'h0,  32'h4, 0, 3);
    cyc("fdrain3",   0, op_nop(),           0, 0,0, 1,3, 0,  1,0, 32'h0,  32'h8, 0, 3);

    // CMP then JE waits for EFLAGS
    cyc("cmp",       1, op_cmp(1,2),        0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 3);
    cyc("je_raw1",   1, op_je(),            0, 0,0, 0,0, 0,  0,0, 32'h0,  32'h0, 1, 3);
    cyc("je_raw2",   1, op_je(),            0, 0,0, 0,0, 0,  0,0, 32'h0,  32'h0, 1, 4);
    cyc("je_wb",     1, op_je(),            0, 0,0, 0,0, 1,  1,1, 32'h0,  32'h0, 1, 5);
    cyc("ef_clear",  0, op_nop(),           0, 0,0, 0,0, 0,  1,0, 32'h0,  32'h0, 0, 5);

    // NOP under load, then flush
    cyc("add7",      1, op_add(7,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 5);
    cyc("cmp2",      1, op_cmp(1,2),        0, 0,0, 0,0, 0,  1,1, 32'h80, 32'h0, 0, 5);
    cyc("nop_busy",  1, op_nop(),           0, 0,0, 0,0, 0,  1,1, 32'h80, 32'h0, 1, 5);
    cyc("flush",     1, op_add(8,7,0),      1, 1,7, 0,0, 1,  0,0, 32'h80, 32'h0, 1, 5);
    cyc("post_fl",   0, op_nop(),           0, 0,0, 0,0, 0,  1,0, 32'h0,  32'h0, 0, 5);

    // Async reset in the middle of a stall
    cyc("add9",      1, op_add(9,1,2),      0, 0,0, 0,0, 0,  1,1, 32'h0,  32'h0, 0, 5);
    cyc("addi10a",   1, op_addi(10,9),      0, 0,0, 0,0, 0,  0,0, 32'h200,32'h0, 0, 5);
    cyc("addi10b",   1, op_addi(10,9),      0, 0,0, 0,0, 0,  0,0, 32'h200,32'h0, 0, 6);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    issue_valid = 1'b0;
    push("async_rst", 1, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc("after_rst", 0, op_nop(),           0, 0,0, 0,0, 0,  1,0, 32'h0,  32'h0, 0, 0);

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
